// File: rtl/dmux_stream_n.sv
// -----------------------------------------------------------------------------
// dmux_stream_n
//
// Registered 1-to-NCH stream demultiplexer. A single producer offers a word
// together with a destination select; the word is written into a one-entry
// buffer belonging to that channel, and each channel presents its buffer to
// an independent consumer through its own valid/ready handshake.
//
// A buffer that is draining in the current cycle can be refilled on the same
// edge, so a channel whose consumer is always ready sustains one word per
// cycle with no bubble. Words addressed to a nonexistent channel
// (in_sel >= NCH) are accepted and discarded. Such words set a sticky error
// flag and are counted by a saturating 8-bit counter.
//
// Parameters
//   WIDTH     : data width in bits (>= 1)
//   NCH       : number of output channels (2..16)
//   SELW      : select width, 2**SELW >= NCH
//   ZERO_IDLE : 1 -> a channel's data reads 0 while its valid is low
//               0 -> a channel's data holds its last buffered word
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : producer has a word
//   in_ready   : word is accepted this cycle (in_valid & in_ready)
//   in_data    : input word
//   in_sel     : destination channel, sampled with in_data
//   out_valid  : bit k -> channel k buffer holds a word
//   out_ready  : bit k -> consumer k takes the word
//   out_data   : channel k at [k*WIDTH +: WIDTH]
//   sel_err    : sticky, a word with an out-of-range select was accepted
//   drop_cnt   : saturating count of discarded words
// -----------------------------------------------------------------------------
module dmux_stream_n #(
    parameter int WIDTH     = 8,
    parameter int NCH       = 4,
    parameter int SELW      = 2,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SELW-1:0]        in_sel,
    output logic [NCH-1:0]         out_valid,
    input  logic [NCH-1:0]         out_ready,
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic                   sel_err,
    output logic [7:0]             drop_cnt
);

    // NCH widened by one bit so the range test cannot overflow when
    // 2**SELW == NCH (in which case every select is in range).
    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

    logic [NCH-1:0]   vld_reg;
    logic [NCH-1:0]   vld_next;
    logic [WIDTH-1:0] data_reg  [NCH];
    logic [WIDTH-1:0] data_next [NCH];
    logic             sel_err_reg;
    logic             sel_err_next;
    logic [7:0]       drop_cnt_reg;
    logic [7:0]       drop_cnt_next;

    logic [NCH-1:0]   sel_hit;   // one-hot decode of in_sel over real channels
    logic [NCH-1:0]   ch_open;   // channel can take a word this cycle
    logic [NCH-1:0]   ch_wr;     // channel is written on the next edge
    logic             sel_ok;
    logic             accept;
    logic             bad_accept;

    assign sel_ok = ({1'b0, in_sel} < NCH_W);

    // The decode is used instead of indexing by in_sel so that an
    // out-of-range select never addresses a nonexistent channel.
    // in_ready depends on in_sel and out_ready only (one mux level).
    assign in_ready   = sel_ok ? |(sel_hit & ch_open) : 1'b1;
    assign accept     = in_valid & in_ready;
    assign bad_accept = accept & ~sel_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign sel_hit[gi] = (in_sel == SELW'(gi));
            // Empty, or draining on this edge: either way the slot is free.
            assign ch_open[gi] = ~vld_reg[gi] | out_ready[gi];
            assign ch_wr[gi]   = accept & sel_hit[gi];

            // A refill wins over a drain, so a drain+refill keeps valid high.
            assign vld_next[gi]  = ch_wr[gi] | (vld_reg[gi] & ~out_ready[gi]);
            assign data_next[gi] = ch_wr[gi] ? in_data : data_reg[gi];

            if (ZERO_IDLE) begin : g_zero
                assign out_data[gi*WIDTH +: WIDTH] = vld_reg[gi] ? data_reg[gi] : '0;
            end else begin : g_hold
                assign out_data[gi*WIDTH +: WIDTH] = data_reg[gi];
            end
        end
    endgenerate

    assign sel_err_next  = sel_err_reg | bad_accept;
    assign drop_cnt_next = (bad_accept && (drop_cnt_reg != 8'hFF))
                           ? drop_cnt_reg + 8'd1 : drop_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg      <= '0;
            sel_err_reg  <= 1'b0;
            drop_cnt_reg <= 8'd0;
            for (int k = 0; k < NCH; k++) begin
                data_reg[k] <= '0;
            end
        end else begin
            vld_reg      <= vld_next;
            sel_err_reg  <= sel_err_next;
            drop_cnt_reg <= drop_cnt_next;
            for (int k = 0; k < NCH; k++) begin
                data_reg[k] <= data_next[k];
            end
        end
    end

    assign out_valid = vld_reg;
    assign sel_err   = sel_err_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_dmux_stream_n.sv
// -----------------------------------------------------------------------------
// tb_dmux_stream_n
//
// Two instances share clock and reset:
//   u_dut  : WIDTH=8, NCH=4, SELW=2, ZERO_IDLE=1 (routing, back-pressure,
//            independence, mid-stream reset)
//   u_dut3 : WIDTH=8, NCH=3, SELW=2, ZERO_IDLE=0 (bad select, hold-on-idle)
// Inputs are driven 1 time unit after a rising edge; in_ready is checked
// before the next edge, registered outputs 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_dmux_stream_n;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        sel_err;
    logic [7:0]  drop_cnt;

    logic        in_valid3;
    logic        in_ready3;
    logic [7:0]  in_data3;
    logic [1:0]  in_sel3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [23:0] out_data3;
    logic        sel_err3;
    logic [7:0]  drop_cnt3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmux_stream_n #(.WIDTH(8), .NCH(4), .SELW(2), .ZERO_IDLE(1'b1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err),
        .drop_cnt  (drop_cnt)
    );

    dmux_stream_n #(.WIDTH(8), .NCH(3), .SELW(2), .ZERO_IDLE(1'b0)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .in_sel    (in_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .sel_err   (sel_err3),
        .drop_cnt  (drop_cnt3)
    );

    typedef struct {
        logic        in_valid;
        logic [1:0]  in_sel;
        logic [7:0]  in_data;
        logic [3:0]  out_ready;
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Routing with all consumers ready, then back-pressure on channel 2.
        vecs[0] = '{1'b1, 2'd0, 8'h11, 4'hF, 1'b1, 4'b0001, 32'h0000_0011};
        vecs[1] = '{1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'b0010, 32'h0000_2200};
        vecs[2] = '{1'b1, 2'd2, 8'h33, 4'hF, 1'b1, 4'b0100, 32'h0033_0000};
        vecs[3] = '{1'b1, 2'd3, 8'h44, 4'hF, 1'b1, 4'b1000, 32'h4400_0000};
        vecs[4] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h0000_0000};
        vecs[5] = '{1'b1, 2'd2, 8'hA5, 4'hB, 1'b1, 4'b0100, 32'h00A5_0000};
        vecs[6] = '{1'b1, 2'd2, 8'h5A, 4'hB, 1'b0, 4'b0100, 32'h00A5_0000};
        vecs[7] = '{1'b1, 2'd2, 8'h5A, 4'hF, 1'b1, 4'b0100, 32'h005A_0000};
        vecs[8] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h0000_0000};

        rst_n      = 1'b0;
        in_valid   = 1'b0;  in_sel  = 2'd0; in_data  = 8'h00; out_ready  = 4'h0;
        in_valid3  = 1'b0;  in_sel3 = 2'd0; in_data3 = 8'h00; out_ready3 = 3'h0;
        #3;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_in_ready",  32'(in_ready),  32'h1);
        step();
        step();
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 9; i++) begin
            in_valid  = vecs[i].in_valid;
            in_sel    = vecs[i].in_sel;
            in_data   = vecs[i].in_data;
            out_ready = vecs[i].out_ready;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
            step();
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
            $display("vec %0d: valid=%0b sel=%0d data=%02h ready_mask=%0h -> out_valid=%04b out_data=%08h",
                     i, vecs[i].in_valid, vecs[i].in_sel, vecs[i].in_data, vecs[i].out_ready,
                     out_valid, out_data);
        end

        // ---------------- independence: ch1 stalled, ch0 streams ----------------
        out_ready = 4'b1101;
        in_valid  = 1'b1; in_sel = 2'd1; in_data = 8'h77;
        #1;
        check("indep_load_ready", 32'(in_ready), 32'h1);
        step();
        check("indep_load_valid", 32'(out_valid), 32'h2);
        for (int i = 0; i < 10; i++) begin
            in_sel  = 2'd0;
            in_data = 8'h80 + 8'(i);
            #1;
            check($sformatf("indep%0d_in_ready", i), 32'(in_ready), 32'h1);
            step();
            check($sformatf("indep%0d_out_valid", i), 32'(out_valid), 32'h3);
            check($sformatf("indep%0d_ch0", i), 32'(out_data[7:0]), 32'h80 + 32'(i));
            check($sformatf("indep%0d_ch1", i), 32'(out_data[15:8]), 32'h77);
            $display("indep %0d: ch0=%02h ch1=%02h out_valid=%04b", i, out_data[7:0], out_data[15:8], out_valid);
        end
        in_sel = 2'd1;
        #1;
        check("indep_ch1_blocked", 32'(in_ready), 32'h0);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        step();
        check("indep_drained", 32'(out_valid), 32'h0);

        // ---------------- bad select on NCH=3 ----------------
        out_ready3 = 3'b111;
        in_valid3  = 1'b1; in_sel3 = 2'd3; in_data3 = 8'hFF;
        for (int i = 0; i < 300; i++) begin
            #1;
            check($sformatf("bad%0d_in_ready", i), 32'(in_ready3), 32'h1);
            step();
            check($sformatf("bad%0d_out_valid", i), 32'(out_valid3), 32'h0);
            check($sformatf("bad%0d_sel_err", i), 32'(sel_err3), 32'h1);
            check($sformatf("bad%0d_drop_cnt", i), 32'(drop_cnt3), (i < 255) ? 32'(i + 1) : 32'd255);
            $display("bad %0d: sel=3 drop_cnt=%0d sel_err=%0b", i, drop_cnt3, sel_err3);
        end
        check("bad_other_sel_err", 32'(sel_err), 32'h0);

        // ---------------- ZERO_IDLE=0: data holds after drain ----------------
        out_ready3 = 3'b000;
        in_sel3 = 2'd0; in_data3 = 8'h3C;
        #1;
        check("hold_in_ready", 32'(in_ready3), 32'h1);
        step();
        check("hold_load_valid", 32'(out_valid3), 32'h1);
        check("hold_load_data",  32'(out_data3),  32'h0000_3C);
        in_valid3  = 1'b0;
        out_ready3 = 3'b111;
        step();
        check("hold_drain_valid", 32'(out_valid3), 32'h0);
        check("hold_drain_data",  32'(out_data3),  32'h0000_3C);
        $display("hold: out_valid3=%03b out_data3=%06h", out_valid3, out_data3);

        // ---------------- asynchronous reset mid-stream ----------------
        out_ready = 4'h0;
        in_valid  = 1'b1;
        in_sel = 2'd0; in_data = 8'h01; step();
        in_sel = 2'd1; in_data = 8'h02; step();
        in_sel = 2'd3; in_data = 8'h04; step();
        in_valid = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 32'hB);
        check("pre_reset_data",  out_data, 32'h0400_0201);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid",  32'(out_valid), 32'h0);
        check("arst_out_data",   out_data,       32'h0);
        check("arst_in_ready",   32'(in_ready),  32'h1);
        check("arst_sel_err3",   32'(sel_err3),  32'h0);
        check("arst_drop_cnt3",  32'(drop_cnt3), 32'h0);
        check("arst_out_data3",  32'(out_data3), 32'h0);
        $display("reset: out_valid=%04b out_data=%08h drop_cnt3=%0d", out_valid, out_data, drop_cnt3);
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_valid", 32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
